// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-precision adder/subtractor: one shared 8-bit add stage,
// walked LSB-first across NBYTES lanes, with the inter-byte carry held in carry_reg.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum_out,
  output logic                  cout,
  output logic [1:0]            state_dbg
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [8:0]      s;

  // The only adder in the block: one byte lane plus the carry from the previous lane.
  always_comb begin
    s = {1'b0, a_reg[idx*8 +: 8]} + {1'b0, b_reg[idx*8 +: 8]} + {8'd0, carry_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_out   <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so the inversion and the +1 happen here once.
            a_reg     <= a_in;
            b_reg     <= op ? ~b_in : b_in;
            carry_reg <= op ? 1'b1 : cin;
            idx       <= '0;
            sum_out   <= '0;
            state     <= ADD;
          end
        end
        ADD: begin
          sum_out[idx*8 +: 8] <= s[7:0];
          carry_reg           <= s[8];
          idx                 <= idx + 1'b1;
          if (idx == LAST) begin
            cout  <= s[8];
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == ADD);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer (NBYTES=4): hand-computed results,
// cycle-exact busy/done checks, start handling and mid-operation reset.
module tb_multibyte_add_sequencer;

  localparam int NBYTES = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum_out;
  logic        cout;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .cout      (cout),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    a_in = $urandom;
    b_in = $urandom;
    op   = 1'($urandom_range(0, 1));
    cin  = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic drive_start(input logic o, input logic [31:0] a, input logic [31:0] b,
                             input logic c);
    op    = o;
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
  endtask

  // Follows one accepted operation from the accepting edge to one cycle past done.
  task automatic track(input string tag, input logic [31:0] exp_sum, input logic exp_cout,
                       input bit repulse);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check({tag, " busy"}, {31'd0, busy}, {31'd0, (i < NBYTES)});
      check({tag, " done"}, {31'd0, done}, {31'd0, (i == NBYTES)});
      if (i == NBYTES) begin
        check({tag, " sum"},  sum_out, exp_sum);
        check({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
      end
      if (i == NBYTES + 1) check({tag, " sum hold"}, sum_out, exp_sum);
      scramble();
      start = repulse && (i == 1 || i == 3);
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input logic [31:0] exp_sum,
                        input logic exp_cout, input bit repulse);
    @(negedge clk);
    drive_start(o, a, b, c);
    track(tag, exp_sum, exp_cout, repulse);
  endtask

  initial begin
    int n_done;
    rst   = 1'b1;
    start = 1'($urandom_range(0, 1));
    scramble();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      scramble();
    end
    check("reset busy",  {31'd0, busy}, 32'd0);
    check("reset done",  {31'd0, done}, 32'd0);
    check("reset sum",   sum_out, 32'h0000_0000);
    check("reset cout",  {31'd0, cout}, 32'd0);
    check("reset state", {30'd0, state_dbg}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;

    run_op("carry8",  1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("ripple",  1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("mixed",   1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    run_op("sub_neg", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos", 1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    run_op("repulse", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b1);

    // start held high: accepts every NBYTES+2 cycles
    @(negedge clk);
    drive_start(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
    @(posedge clk);
    n_done = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      check("hold busy", {31'd0, busy}, {31'd0, ((j % 6) < 4)});
      check("hold done", {31'd0, done}, {31'd0, ((j % 6) == 4)});
      if (j < 20 && done) n_done++;
      if (j == 22) check("hold sum", sum_out, 32'h0001_0001);
      if (j == 19) start = 1'b0;
    end
    check("hold done count", n_done, 32'd3);

    // reset two edges into an operation
    @(negedge clk);
    drive_start(1'b0, 32'h1122_3344, 32'h0101_0101, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort lane0", sum_out, 32'h0000_0045);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort sum",  sum_out, 32'h0000_0000);
    check("abort cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    drive_start(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    track("post_abort", 32'h0000_0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
